mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_array_sp.sv | 44 ++++
 rtl/mem_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : mem_pkg                                                    |
// | Description : Shared constants for the memory-stage responder: data     |
// |               width, wait-counter width and FSM state encoding.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mem_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_CNT_W  = 4;
    localparam int c_ST_W   = 2;

    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_WAIT = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_RESP = 2'd2;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array_sp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_array_sp                                               |
// | Description : Single-port word array. Synchronous write, registered      |
// |               read (read-before-write on a combined access). No reset,   |
// |               so contents survive a responder reset.                     |
// | Ports       : clk      - clock                                           |
// |               i_en     - access enable (read register updates only here) |
// |               i_we     - write enable, qualified by i_en                 |
// |               i_addr   - word index                                      |
// |               i_wdata  - write data                                      |
// |               o_rdata  - registered read data                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_array_sp
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6
) (
    input  logic                clk,
    input  logic                i_en,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [c_DATA_W-1:0] i_wdata,
    output logic [c_DATA_W-1:0] o_rdata
);

    logic [c_DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [c_DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : mem_array_sp
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_responder                                              |
// | Description : Memory-stage request/response responder with a fixed      |
// |               number of wait states in front of a single-port array.    |
// |               IDLE -> WAIT (WAIT_CYCLES) -> RESP, response held until   |
// |               the pipeline consumes it.                                  |
// | Ports       : clk, reset (async, active-low)                             |
// |               req_valid/req_ready/req_write/req_addr/req_wdata - request |
// |               rsp_valid/rsp_ready/rsp_rdata/rsp_err            - response|
// |               busy - high whenever not IDLE (memory-stage stall)         |
// | Config      : MEM_ALIGN_CHECK_EN - when defined, accesses with           |
// |               req_addr[1:0] != 0 are faulted (no store, rdata 0, err 1). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int                 c_ADDR_W    = $clog2(DEPTH_WORDS);
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(WAIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam bit                 c_NO_WAIT   = (WAIT_CYCLES == 0);

    logic [c_ST_W-1:0]   r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_reqReady;
    logic                r_write;
    logic [c_ADDR_W-1:0] r_wordAddr;
    logic [c_DATA_W-1:0] r_wdata;
    logic                r_misaligned;

    logic                w_accept;
    logic                w_inIdle;
    logic                w_inResp;
    logic                w_enterResp;
    logic                w_memWrite;
    logic                w_memWe;
    logic [c_ADDR_W-1:0] w_memAddr;
    logic [c_DATA_W-1:0] w_memWdata;
    logic [c_DATA_W-1:0] w_memRdata;
    logic                w_reqMisaligned;
    logic                w_misaligned;

    // r_reqReady is only ever set while IDLE, so it alone qualifies acceptance.
    assign w_accept = req_valid & r_reqReady;
    assign w_inIdle = (r_state == c_ST_IDLE);
    assign w_inResp = (r_state == c_ST_RESP);

    // The array access happens on the edge that enters RESP. With no wait
    // states that is the acceptance edge itself, so the live request is used.
    assign w_enterResp = (w_inIdle & w_accept & c_NO_WAIT)
                       | ((r_state == c_ST_WAIT) & (r_cnt == c_CNT_ONE));

    assign w_memWrite = w_inIdle ? req_write                    : r_write;
    assign w_memAddr  = w_inIdle ? req_addr[c_ADDR_W+1:2]       : r_wordAddr;
    assign w_memWdata = w_inIdle ? req_wdata                    : r_wdata;

`ifdef MEM_ALIGN_CHECK_EN
    logic [31-(c_ADDR_W+2):0] w_unusedAddr;
    assign w_unusedAddr    = req_addr[31:c_ADDR_W+2];
    assign w_reqMisaligned = (req_addr[1:0] != 2'b00);
    assign w_misaligned    = w_inIdle ? w_reqMisaligned : r_misaligned;
    assign w_memWe         = w_memWrite & ~w_misaligned;
    assign rsp_err         = w_inResp & r_misaligned;
    assign rsp_rdata       = (w_inResp & ~r_write & ~r_misaligned) ? w_memRdata : '0;
`else
    logic [31-(c_ADDR_W+2)+2:0] w_unusedAddr;
    assign w_unusedAddr    = {req_addr[31:c_ADDR_W+2], req_addr[1:0]};
    assign w_reqMisaligned = 1'b0;
    assign w_misaligned    = 1'b0;
    assign w_memWe         = w_memWrite;
    assign rsp_err         = 1'b0;
    assign rsp_rdata       = (w_inResp & ~r_write) ? w_memRdata : '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_reqReady   <= 1'b0;
            r_write      <= 1'b0;
            r_wordAddr   <= '0;
            r_wdata      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_reqReady <= 1'b1;
                    if (w_accept) begin
                        r_reqReady   <= 1'b0;
                        r_write      <= req_write;
                        r_wordAddr   <= req_addr[c_ADDR_W+1:2];
                        r_wdata      <= req_wdata;
                        r_misaligned <= w_reqMisaligned;
                        if (c_NO_WAIT) begin
                            r_state <= c_ST_RESP;
                        end else begin
                            r_state <= c_ST_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_ST_RESP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ST_RESP: begin
                    // Ready rises together with the return to IDLE, so the
                    // handshake edge itself can never accept a new request.
                    if (rsp_ready) begin
                        r_state    <= c_ST_IDLE;
                        r_reqReady <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_cnt      <= '0;
                    r_reqReady <= 1'b0;
                end
            endcase
        end
    end

    mem_array_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_enterResp),
        .i_we    (w_memWe),
        .i_addr  (w_memAddr),
        .i_wdata (w_memWdata),
        .o_rdata (w_memRdata)
    );

    assign req_ready = r_reqReady;
    assign rsp_valid = w_inResp;
    assign busy      = ~w_inIdle;

endmodule : mem_responder
`default_nettype wire
